// File: rtl/k_coef_mem.sv
// k_coef_mem: writable coefficient table that replaces the fixed k-constant ROM.
// Words are stored as Q8.24 and served as saturated DWIDTH-bit fixed point,
// either as single registered reads or as auto-incrementing bursts.
module k_coef_mem #(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 4,
  parameter int DWIDTH_TMP = 32,
  parameter int SLICE_MSB  = 29
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AWIDTH-1:0]     wr_addr,
  input  logic [DWIDTH_TMP-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AWIDTH-1:0]     rd_addr,
  input  logic                  burst_start,
  input  logic [AWIDTH-1:0]     burst_len,
  output logic [DWIDTH-1:0]     dout,
  output logic                  dout_valid,
  output logic                  sat,
  output logic                  busy,
  output logic                  burst_done
);

  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state_q, state_d;
  logic [AWIDTH-1:0]       addr_q, addr_d;
  logic [AWIDTH-1:0]       cnt_q, cnt_d;
  logic                    rd_vld_q, rd_vld_d;
  logic [DWIDTH-1:0]       rd_dout_q, rd_dout_d;
  logic                    rd_sat_q, rd_sat_d;
  logic [DWIDTH_TMP-1:0]   mem_q [DEPTH];
  logic [DWIDTH_TMP-1:0]   mem_d [DEPTH];
  logic [DWIDTH:0]         rd_conv, bu_conv;

  // Power-up contents: 8.0, 5.0, 8.0, 5.0, then zeros.
  function automatic logic [DWIDTH_TMP-1:0] dflt(input int idx);
    case (idx)
      0, 2:    dflt = DWIDTH_TMP'(32'h0800_0000);
      1, 3:    dflt = DWIDTH_TMP'(32'h0500_0000);
      default: dflt = '0;
    endcase
  endfunction

  // Q8.24 -> output format; any set bit above the slice saturates to all ones.
  // Result is {sat, data}. Dropped LSBs are truncated.
  function automatic logic [DWIDTH:0] conv(input logic [DWIDTH_TMP-1:0] w);
    logic [DWIDTH_TMP-1:0] ovf;
    ovf = w >> (SLICE_MSB + 1);
    if (ovf != '0) conv = {1'b1, {DWIDTH{1'b1}}};
    else           conv = {1'b0, w[SLICE_MSB -: DWIDTH]};
  endfunction

  assign rd_conv = conv(mem_q[rd_addr]);
  assign bu_conv = conv(mem_q[addr_q]);

  // Write port: accepted in every state; reads of the same edge see old data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (wr_en) mem_d[wr_addr] = wr_data;
  end

  // Control FSM: single reads and burst launch in IDLE, beat sequencing in BURST.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rd_vld_d  = 1'b0;
    rd_dout_d = '0;
    rd_sat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (burst_start) begin
          state_d = BURST;
          addr_d  = rd_addr;
          cnt_d   = burst_len;
        end else if (rd_en) begin
          rd_vld_d  = 1'b1;
          rd_dout_d = rd_conv[DWIDTH-1:0];
          rd_sat_d  = rd_conv[DWIDTH];
        end
      end
      BURST: begin
        // Requests arriving while busy are dropped.
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, single-read holding register and memory; reset restores defaults.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      rd_vld_q  <= 1'b0;
      rd_dout_q <= '0;
      rd_sat_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= dflt(i);
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= rd_vld_d;
      rd_dout_q <= rd_dout_d;
      rd_sat_q  <= rd_sat_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  // Output mux: burst beats read memory live so late writes are picked up;
  // with no valid beat the bus is driven to zero.
  always_comb begin
    dout       = '0;
    sat        = 1'b0;
    dout_valid = 1'b0;
    busy       = (state_q == BURST);
    burst_done = 1'b0;
    if (state_q == BURST) begin
      dout       = bu_conv[DWIDTH-1:0];
      sat        = bu_conv[DWIDTH];
      dout_valid = 1'b1;
      burst_done = (cnt_q == '0);
    end else if (rd_vld_q) begin
      dout       = rd_dout_q;
      sat        = rd_sat_q;
      dout_valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_k_coef_mem.sv
// Directed bench for k_coef_mem: inputs driven and outputs sampled on negedge.
module tb_k_coef_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        burst_start;
  logic [3:0]  burst_len;
  logic [15:0] dout;
  logic        dout_valid, sat, busy, burst_done;

  int n_run  = 0;
  int n_fail = 0;

  k_coef_mem dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .burst_start(burst_start), .burst_len(burst_len),
    .dout(dout), .dout_valid(dout_valid), .sat(sat), .busy(busy), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Check the full output bundle in one go.
  task automatic chk_out(input string tag, input logic [15:0] d, input logic v,
                         input logic s, input logic b, input logic dn);
    chk({tag, ".dout"}, 32'(dout), 32'(d));
    chk({tag, ".vld"},  32'(dout_valid), 32'(v));
    chk({tag, ".sat"},  32'(sat), 32'(s));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(burst_done), 32'(dn));
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_en = 0; rd_addr = 0; burst_start = 0; burst_len = 0;
    @(negedge clk);
    chk_out("reset", 16'h0, 0, 0, 0, 0);
    rst = 1'b0;

    // Back-to-back single reads of defaults
    @(negedge clk); rd_en = 1; rd_addr = 0;
    @(negedge clk); chk_out("rd0", 16'h2000, 1, 0, 0, 0); rd_addr = 1;
    @(negedge clk); chk_out("rd1", 16'h1400, 1, 0, 0, 0); rd_addr = 4;
    @(negedge clk); chk_out("rd4", 16'h0000, 1, 0, 0, 0); rd_en = 0;
    @(negedge clk); chk_out("rd_idle", 16'h0, 0, 0, 0, 0);

    // Saturating and small-value conversion
    wr_en = 1; wr_addr = 5; wr_data = 32'h4000_0000;
    @(negedge clk); wr_en = 0; rd_en = 1; rd_addr = 5;
    @(negedge clk); chk_out("sat5", 16'hFFFF, 1, 1, 0, 0);
    rd_en = 0; wr_en = 1; wr_addr = 6; wr_data = 32'h0000_4000;
    @(negedge clk); wr_en = 0; rd_en = 1; rd_addr = 6;
    @(negedge clk); chk_out("lsb6", 16'h0001, 1, 0, 0, 0); rd_en = 0;

    // Wrapping burst 14,15,0,1 with requests pulsed while busy
    @(negedge clk); burst_start = 1; rd_addr = 14; burst_len = 3;
    @(negedge clk); burst_start = 0; chk_out("b1", 16'h0000, 1, 0, 1, 0);
    rd_en = 1; burst_start = 1; rd_addr = 4; burst_len = 0;
    @(negedge clk); chk_out("b2", 16'h0000, 1, 0, 1, 0); rd_en = 0; burst_start = 0;
    @(negedge clk); chk_out("b3", 16'h2000, 1, 0, 1, 0); rd_en = 1; rd_addr = 1;
    @(negedge clk); chk_out("b4", 16'h1400, 1, 0, 1, 1); rd_en = 0;
    @(negedge clk); chk_out("b_end", 16'h0, 0, 0, 0, 0);

    // Same-edge read/write at addr 2: read-first
    wr_en = 1; wr_addr = 2; wr_data = 32'h0100_0000; rd_en = 1; rd_addr = 2;
    @(negedge clk); chk_out("col_old", 16'h2000, 1, 0, 0, 0); wr_en = 0;
    @(negedge clk); chk_out("col_new", 16'h0400, 1, 0, 0, 0); rd_en = 0;

    // Overwrite addr 0, start 16-beat burst, reset during beat 2
    wr_en = 1; wr_addr = 0; wr_data = 32'h4000_0000;
    @(negedge clk); wr_en = 0; burst_start = 1; rd_addr = 0; burst_len = 15;
    @(negedge clk); burst_start = 0; chk_out("rb1", 16'hFFFF, 1, 1, 1, 0);
    @(negedge clk); chk_out("rb2", 16'h1400, 1, 0, 1, 0);
    #2 rst = 1'b1;
    #1 chk_out("rb_rst", 16'h0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_out("rb_after", 16'h0, 0, 0, 0, 0);
    end
    rd_en = 1; rd_addr = 0;
    @(negedge clk); chk_out("rb_dflt0", 16'h2000, 1, 0, 0, 0); rd_addr = 2;
    @(negedge clk); chk_out("rb_dflt2", 16'h2000, 1, 0, 0, 0); rd_en = 0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/k_coef_mem.md
Name: k_coef_mem

Overview:
- Parametrised, writable successor to the fixed k-constant table in the backprop network.
- Stores DEPTH coefficient words internally at DWIDTH_TMP bits (Q8.24), loads defaults on reset and accepts runtime overwrites.
- Serves either single registered reads or auto-incrementing bursts, converting each word to DWIDTH-bit fixed point (default Q6.10) with saturation.
- Feeds the learning-rate/coefficient inputs of the weight-update datapath.

Parameters:
- DWIDTH, 16: output data width.
- AWIDTH, 4: address width; DEPTH = 2**AWIDTH.
- DWIDTH_TMP, 32: stored word width, Q8.24.
- SLICE_MSB, 29: MSB of the output slice. dout = word[SLICE_MSB -: DWIDTH]. Requires SLICE_MSB+1 >= DWIDTH and SLICE_MSB < DWIDTH_TMP.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: write strobe.
- wr_addr, input, AWIDTH: write address.
- wr_data, input, DWIDTH_TMP: write data, Q8.24.
- rd_en, input, 1: single-read request.
- rd_addr, input, AWIDTH: read address for a single read; start address for a burst.
- burst_start, input, 1: start a burst.
- burst_len, input, AWIDTH: beats minus one (0 = 1 beat, all ones = DEPTH beats).
- dout, output, DWIDTH: sliced or saturated data.
- dout_valid, output, 1: dout holds a valid beat this cycle.
- sat, output, 1: the current beat was saturated.
- busy, output, 1: burst in progress.
- burst_done, output, 1: one-cycle pulse coinciding with the last burst beat.

Behaviour:
- Reset (async assert, sync release):
  - Memory loads defaults: addr0 = 0x08000000 (8.0), addr1 = 0x05000000 (5.0), addr2 = 8.0, addr3 = 5.0, all other addresses 0.
  - dout = 0, dout_valid = 0, sat = 0, busy = 0, burst_done = 0; FSM goes to IDLE.
  - A reset asserted mid-burst aborts the burst with no done pulse.
- Output is never tristated. When no beat is valid, dout = 0 and sat = 0.
- Conversion: bits above SLICE_MSB are the unsigned overflow field.
  - Overflow field all zero: dout = word[SLICE_MSB -: DWIDTH], sat = 0. Dropped LSBs are truncated, not rounded.
  - Overflow field nonzero: dout = all ones, sat = 1.
- Write: on a clk edge with wr_en = 1, mem[wr_addr] <= wr_data. Writes are accepted in every state.
- Single read:
  - Taken only in IDLE when rd_en = 1 and burst_start = 0.
  - Latency 1: a request at edge N gives dout/dout_valid after edge N+1, held for one cycle.
  - Back-to-back requests give back-to-back valid beats.
- Read/write collision at the same address on the same edge: the read returns the old data (read-first). The new data is visible from the next edge.
- FSM, IDLE:
  - burst_start = 1: latch addr = rd_addr and cnt = burst_len, go to BURST, busy = 1 from the next cycle.
  - burst_start has priority over rd_en on the same edge.
- FSM, BURST:
  - Each cycle emit mem[addr] with dout_valid = 1, then addr <= addr+1 modulo DEPTH (wraps 15 -> 0) and cnt <= cnt-1.
  - The first beat appears in the cycle after the start edge.
  - On the beat with cnt = 0, burst_done = 1, and the FSM returns to IDLE on the same edge.
  - busy deasserts in the cycle after the last beat; dout_valid drops then unless a new request was accepted.
- While busy = 1, rd_en and burst_start are ignored (dropped, not queued).
- A new burst_start is accepted on the edge that retires the last beat only if busy is already low, i.e. one cycle gap minimum.
- Writes to an address not yet reached in the burst are seen by that beat (memory is read at beat time).

Test Plan:
- Reset then single reads of addr 0,1,4 back-to-back -> dout 0x2000, 0x1400, 0x0000 on consecutive cycles, dout_valid high for 3 cycles, sat = 0.
- Write 0x40000000 to addr 5, then read addr 5 -> dout = 0xFFFF, sat = 1. Write 0x00004000 to addr 6, then read -> dout = 0x0001, sat = 0.
- Burst rd_addr = 14, burst_len = 3 -> beats from addr 14, 15, 0, 1 = 0, 0, 0x2000, 0x1400. burst_done on the 4th beat, busy high for exactly 4 cycles.
- rd_en and burst_start pulsed during a burst -> ignored, no extra beats, burst content unchanged.
- Same-edge write 0x01000000 and read at addr 2 -> the read returns 0x2000; the next read returns 0x0400.
- Assert rst during the 2nd beat of a 16-beat burst after overwriting addr 0 -> all outputs 0 immediately, busy = 0, no burst_done. A later read of addr 0 returns 0x2000 (default restored).
